// File: rtl/simple_if_arb_pkg.sv
// rtl/simple_if_arb_pkg.sv - shared defaults and types for the round-robin channel arbiter
package simple_if_arb_pkg;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_CNT_W   = 16;

   typedef logic [DEF_DATA_W-1:0]          data_t;
   typedef logic [$clog2(DEF_NUM_REQ)-1:0] req_idx_t;

endpackage

// File: rtl/simple_if_arbiter_rr_pick.sv
// rtl/simple_if_arbiter_rr_pick.sv - combinational round-robin picker starting after the last winner
module rr_pick
   import simple_if_arb_pkg::*;
#(
   parameter int N = DEF_NUM_REQ
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic                 found_o,
   output logic [$clog2(N)-1:0] winner_o
);

   localparam int IW = $clog2(N);

   // Scan ptr+1, ptr+2, ... modulo N; the first asserted request wins.
   always_comb begin
      found_o  = 1'b0;
      winner_o = '0;
      for (int k = 1; k <= N; k++) begin
         if (!found_o && req_i[(int'(ptr_i) + k) % N]) begin
            found_o  = 1'b1;
            winner_o = IW'((int'(ptr_i) + k) % N);
         end
      end
   end

endmodule

// File: rtl/simple_if_arbiter.sv
// rtl/simple_if_arbiter.sv - round-robin arbiter feeding a one-entry valid/ready output register
module simple_if_arbiter
   import simple_if_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic [CNT_W-1:0]           xfer_count
);

   localparam int IW = $clog2(NUM_REQ);

   logic              out_valid_q,  out_valid_d;
   logic [DATA_W-1:0] out_data_q,   out_data_d;
   logic [IW-1:0]     grant_id_q,   grant_id_d;
   logic [IW-1:0]     rr_ptr_q,     rr_ptr_d;
   logic [CNT_W-1:0]  xfer_count_q, xfer_count_d;

   logic          slot_free;
   logic          found;
   logic [IW-1:0] winner;
   logic          xfer;

   rr_pick #(
      .N (NUM_REQ)
   ) u_rr_pick (
      .req_i    (req_valid),
      .ptr_i    (rr_ptr_q),
      .found_o  (found),
      .winner_o (winner)
   );

   // The slot can take new data when empty or when the consumer drains it this cycle.
   assign slot_free = !out_valid_q || out_ready;

   // Only the round-robin winner sees ready, and never while reset is held.
   always_comb begin
      req_ready = '0;
      if (!rst && found && slot_free) begin
         req_ready[winner] = 1'b1;
      end
   end

   assign xfer = |(req_valid & req_ready);

   // Next state: a transfer loads the slot (even when draining), otherwise a consume empties it.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      grant_id_d   = grant_id_q;
      rr_ptr_d     = rr_ptr_q;
      xfer_count_d = xfer_count_q;
      if (xfer) begin
         out_valid_d  = 1'b1;
         out_data_d   = req_data[int'(winner)*DATA_W +: DATA_W];
         grant_id_d   = winner;
         rr_ptr_d     = winner;
         xfer_count_d = xfer_count_q + CNT_W'(1);
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State register; reset parks the pointer on the last requester so requester 0 leads.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         grant_id_q   <= '0;
         rr_ptr_q     <= IW'(NUM_REQ - 1);
         xfer_count_q <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         grant_id_q   <= grant_id_d;
         rr_ptr_q     <= rr_ptr_d;
         xfer_count_q <= xfer_count_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign grant_id   = grant_id_q;
   assign xfer_count = xfer_count_q;

endmodule
